// File: rtl/bin2bcd_if.sv
// bin2bcd_if -- request/result bundle for the sequential binary-to-BCD converter.
//
// Signals:
//   start     master -> slave  request a conversion of bin
//   bin       master -> slave  32-bit unsigned operand
//   busy      slave -> master  conversion in progress
//   done      slave -> master  one-cycle completion pulse
//   bcd       slave -> master  packed 8-digit BCD result (held)
//   ovf       slave -> master  operand exceeded 99,999,999 (held with bcd)
//   dbg_state slave -> master  current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// converter is idle (busy=0); bin is sampled on that same edge only. start
// while busy=1 is dropped, not queued. Completion is the single-cycle done
// pulse, and bcd/ovf change only on the edge that raises done. The done cycle
// is already idle, so a new start there is accepted.
interface bin2bcd_if;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        ovf;
  logic        dbg_state;

  modport master (
    output start, bin,
    input  busy, done, bcd, ovf, dbg_state
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, ovf, dbg_state
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential 32-bit binary to 8-digit packed-BCD converter
// using shift-and-add-3, one operand bit per clock (32 clocks per result).
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    bin2bcd_if.slave: start/bin in; busy/done/bcd/ovf/dbg_state out
//
// Build option:
//   BIN2BCD_SATURATE_EN  when defined, overflowing operands report
//                        bcd = 32'h99999999; otherwise bcd carries the
//                        low 8 decimal digits. ovf is set either way.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  bin2bcd_if.slave    bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [39:0] acc_q, acc_d;   // 10 BCD digits: enough for 4,294,967,295
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic [39:0] acc_adj;
  logic [39:0] acc_shift;
  logic        ovf_now;

  always_comb begin
    // Any digit >= 5 would become >= 10 when doubled; adding 3 first makes
    // the doubling carry into the next digit instead.
    acc_adj = acc_q;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[38:0], sr_q[31]};
    ovf_now   = |acc_shift[39:32];
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          sr_d    = bus.bin;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        sr_d  = {sr_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        // Last bit: the shifted value is final, publish it directly.
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = ovf_now;
`ifdef BIN2BCD_SATURATE_EN
          bcd_d   = ovf_now ? 32'h9999_9999 : acc_shift[31:0];
`else
          bcd_d   = acc_shift[31:0];
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- bench for bin2bcd_seq: fixed vector table, randomized
// operands against a decimal-arithmetic reference, and hand-written
// sequences for ignored start, back-to-back restart and mid-run reset.
module tb_bin2bcd_seq;

  logic clk;
  logic reset;
  bin2bcd_if bif ();

  bin2bcd_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int applied;
  int miscompares;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain decimal arithmetic on the operand.
  function automatic void model(input logic [31:0] v, output logic [31:0] b, output logic o);
    longint unsigned x;
    x = 64'(v);
    o = (x > 64'd99999999);
    x = x % 64'd100000000;
    b = '0;
    for (int d = 0; d < 8; d++) begin
      b[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_SATURATE_EN
    if (o) b = 32'h9999_9999;
`endif
  endfunction

  // Called just after the accept edge; returns done latency (-1 on timeout)
  // and the number of sampled cycles with busy high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bif.busy) busy_cnt++;
      tick();
      if (bif.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_conv(input logic [31:0] v, input logic [31:0] exp_bcd,
                          input logic exp_ovf, input string name);
    int lat, bc;
    bif.start = 1'b1;
    bif.bin   = v;
    tick();
    bif.start = 1'b0;
    bif.bin   = $urandom;   // operand must not matter after acceptance
    wait_done(lat, bc);
    check({name, "_latency"}, 64'(lat), 64'd32);
    check({name, "_busy_cycles"}, 64'(bc), 64'd32);
    check({name, "_bcd"}, 64'(bif.bcd), 64'(exp_bcd));
    check({name, "_ovf"}, 64'(bif.ovf), 64'(exp_ovf));
    tick();
    check({name, "_done_single"}, 64'(bif.done), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int lat, bc;
    logic [31:0] rb, eb;
    logic ro;
    bit seen;

    applied = 0;
    miscompares = 0;

    vecs[0] = '{32'd0,          32'h0000_0000, 1'b0};
    vecs[1] = '{32'd12345678,   32'h1234_5678, 1'b0};
    vecs[2] = '{32'd99999999,   32'h9999_9999, 1'b0};
`ifdef BIN2BCD_SATURATE_EN
    vecs[3] = '{32'd100000000,  32'h9999_9999, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF,  32'h9999_9999, 1'b1};
`else
    vecs[3] = '{32'd100000000,  32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF,  32'h9496_7295, 1'b1};
`endif
    vecs[5] = '{32'd1,          32'h0000_0001, 1'b0};

    reset = 1'b1;
    bif.start = 1'b0;
    bif.bin = '0;
    tick();
    tick();
    reset = 1'b0;

    check("reset_busy", 64'(bif.busy), 64'd0);
    check("reset_done", 64'(bif.done), 64'd0);
    check("reset_bcd",  64'(bif.bcd),  64'd0);
    check("reset_ovf",  64'(bif.ovf),  64'd0);
    check("reset_state", 64'(bif.dbg_state), 64'd0);

    // Fixed table
    for (int i = 0; i < 6; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Random operands, half biased into the non-overflow range
    for (int i = 0; i < 20; i++) begin
      rb = (i % 2 == 0) ? 32'($urandom_range(0, 99999999)) : $urandom;
      model(rb, eb, ro);
      run_conv(rb, eb, ro, $sformatf("rnd%0d_%0d", i, rb));
    end

    // start while busy is dropped: 7 at E0, 9 at E10 -> single done with 7
    bif.start = 1'b1;
    bif.bin = 32'd7;
    tick();                                   // E0
    bif.start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();      // E1..E9
    bif.start = 1'b1;
    bif.bin = 32'd9;
    tick();                                   // E10
    bif.start = 1'b0;
    lat = -1;
    for (int k = 11; k <= 45; k++) begin
      tick();
      if (bif.done) begin
        lat = k;
        break;
      end
    end
    check("ignored_start_latency", 64'(lat), 64'd32);
    check("ignored_start_bcd", 64'(bif.bcd), 64'h7);

    // Restart on the done cycle
    bif.start = 1'b1;
    bif.bin = 32'd9;
    tick();                                   // E33 accept
    bif.start = 1'b0;
    check("b2b_done_cleared", 64'(bif.done), 64'd0);
    check("b2b_busy", 64'(bif.busy), 64'd1);
    wait_done(lat, bc);
    check("b2b_latency", 64'(lat), 64'd32);
    check("b2b_bcd", 64'(bif.bcd), 64'h9);
    check("b2b_ovf", 64'(bif.ovf), 64'd0);
    tick();

    // Reset mid-conversion
    bif.start = 1'b1;
    bif.bin = 32'd123;
    tick();                                   // E0
    bif.start = 1'b0;
    for (int k = 1; k <= 14; k++) tick();
    reset = 1'b1;
    tick();                                   // E15
    reset = 1'b0;
    check("midreset_busy", 64'(bif.busy), 64'd0);
    check("midreset_done", 64'(bif.done), 64'd0);
    check("midreset_bcd", 64'(bif.bcd), 64'd0);
    check("midreset_ovf", 64'(bif.ovf), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bif.done || bif.busy) seen = 1'b1;
    end
    check("midreset_quiet", 64'(seen), 64'd0);
    run_conv(32'd42, 32'h42, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential 32-bit binary to 8-digit packed-BCD converter (shift-and-add-3, one bit per clock). It sits directly upstream of the 8-digit seven-segment scanner: `done` drives the scanner's `cs` and `bcd` drives its `i_data`, so CPU register or memory values are shown in decimal instead of hex. Values above 99,999,999 set an overflow flag.

## Interface
- None. Widths are fixed: 32-bit input, 8 BCD digits out, 10-digit internal accumulator.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a conversion of `bin`; sampled only while idle.
- `bin`  in  32  unsigned binary operand; sampled on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd` and `ovf` are updated on the same edge.
- `bcd`  out  32  packed BCD result, digit 0 in [3:0] through digit 7 in [31:28]; held until the next completion.
- `ovf`  out  1  high when the operand is greater than 99,999,999; held with `bcd`.

## Operation
- States:
  - IDLE:
    - `start`=1 -> SHIFT.
    - On that edge: shift register <= `bin`, 40-bit accumulator <= 0, bit counter <= 0, `busy` <= 1.
  - SHIFT:
    - Each edge, every accumulator nibble >= 5 gets +3.
    - Then {acc, sr} shifts left by 1 (sr MSB enters acc LSB), and the counter increments.
    - On the edge where counter == 31: apply the final adjusted shift into the outputs.
    - Outputs on that edge: `bcd` <= acc[31:0], `ovf` <= (acc[39:32] != 0), `done` <= 1, `busy` <= 0, -> IDLE.
- `done` is cleared on every edge where it is not being set.
- `start` during SHIFT is ignored; it is not queued.
- `start` in the cycle where `done`=1 is accepted, because the FSM is already in IDLE.
- Nibble adjust is combinational on the current accumulator; no nibble can exceed 9 after the shift.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=32'h0, `ovf`=0, FSM=IDLE, counter=0.
- Accept edge E0 (`start`=1, IDLE). `busy` is high from E0 through E32, i.e. 32 cycles.
- `done` is high for exactly the one cycle after E32. Latency from start sample to `done` is 32 clocks.
- Maximum throughput is one conversion per 33 clocks (restart on the `done` cycle).
- Reset mid-conversion: the conversion is abandoned with no `done` pulse. `bcd`/`ovf` go to 0 on that edge.
- `bin` may change freely after E0.

## Configuration
- `BIN2BCD_SATURATE_EN` defined:
  - On overflow, `bcd` <= 32'h99999999 and `ovf` <= 1.
- `BIN2BCD_SATURATE_EN` undefined:
  - On overflow, `bcd` holds the low 8 decimal digits (value mod 10^8) and `ovf` <= 1.
- Non-overflow results are identical in both builds.

## Test plan
- After reset, `bin`=0, `start` pulse: `done` at E0+32, `bcd`=32'h00000000, `ovf`=0, `busy` high for exactly 32 cycles.
- `bin`=12,345,678 -> `bcd`=32'h12345678, `ovf`=0. `bin`=99,999,999 -> `bcd`=32'h99999999, `ovf`=0.
- `bin`=100,000,000 -> `ovf`=1, `bcd`=32'h00000000 (or 32'h99999999 with saturate).
- `bin`=32'hFFFFFFFF -> `ovf`=1, `bcd`=32'h94967295 (or 32'h99999999 with saturate).
- Start ignored while busy, then back-to-back:
  - `start`+`bin`=7 at E0; `start`+`bin`=9 at E10 -> single `done` at E32 with 32'h7.
  - `start`+`bin`=9 on the `done` cycle -> second `done` 32 clocks later with 32'h9.
- Reset mid-conversion: `reset` at E15 -> no `done`, `busy`=0, `bcd`=0. A fresh start of 42 -> 32'h42 after 32 clocks.
